// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        LONG_HELD,
        WAIT_REL
    } btn_state_t;

    localparam int DEF_TICK_DIV = 100_000;
    localparam int DEF_LONG_T   = 500;
    localparam int DEF_DCLICK_T = 250;
    localparam int DEF_REPEAT_T = 100;
    localparam int DEF_CNT_W    = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Debounced level in, gesture event pulses and held level out.
interface button_event_decoder_if;
    logic db_in;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_pulse;
    logic held;

    modport master (
        output db_in,
        input  short_press, long_press, double_click, repeat_pulse, held
    );

    modport slave (
        input  db_in,
        output short_press, long_press, double_click, repeat_pulse, held
    );
endinterface

// File: rtl/button_event_decoder_tick.sv
// Free-running modulo-M counter; max_tick pulses for one clk every M clks.
module mod_m_counter #(
    parameter int M = 10,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         reset,
    output logic         max_tick,
    output logic [N-1:0] q
);
    logic [N-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= '0;
        else if (r_q == N'(M - 1))
            r_q <= '0;
        else
            r_q <= r_q + 1'b1;
    end

    assign q        = r_q;
    assign max_tick = (r_q == N'(M - 1));
endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into short/long/double-click pulses plus a held level.
// Define AUTO_REPEAT_EN to emit repeat_pulse every REPEAT_T ticks while long-held.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int LONG_T   = DEF_LONG_T,
    parameter int DCLICK_T = DEF_DCLICK_T,
    parameter int REPEAT_T = DEF_REPEAT_T,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    button_event_decoder_if.slave  bus
);
    localparam int MAX_T = max3(LONG_T, DCLICK_T, REPEAT_T);

    if (MAX_T > (1 << CNT_W) - 1) begin : g_cnt_w_check
        $error("CNT_W too narrow for the configured tick counts");
    end

    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    logic             r_db_q;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_dclick;
    logic             r_held;
`ifdef AUTO_REPEAT_EN
    logic             r_repeat;
`endif

    mod_m_counter #(.M(TICK_DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .max_tick (w_tick),
        .q        ()
    );

    assign w_rise    = bus.db_in & ~r_db_q;
    assign w_fall    = ~bus.db_in & r_db_q;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // db_q resets high so a button already held at reset release is not seen as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_q   <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_dclick <= 1'b0;
            r_held   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_repeat <= 1'b0;
`endif
        end else begin
            r_db_q   <= bus.db_in;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_dclick <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            if (w_tick)
                r_cnt <= w_cnt_inc;
            // Edges are checked before tick compares so an edge always wins a same-cycle tick.
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESS1;
                        r_cnt   <= '0;
                        r_held  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (w_fall) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end else if (w_tick && r_cnt == CNT_W'(LONG_T - 1)) begin
                        r_state <= LONG_HELD;
                        r_cnt   <= '0;
                        r_long  <= 1'b1;
                    end
                end
                GAP: begin
                    if (w_rise) begin
                        r_state  <= WAIT_REL;
                        r_cnt    <= '0;
                        r_held   <= 1'b1;
                        r_dclick <= 1'b1;
                    end else if (w_tick && r_cnt == CNT_W'(DCLICK_T - 1)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_short <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (w_tick && r_cnt == CNT_W'(REPEAT_T - 1)) begin
                        r_cnt    <= '0;
                        r_repeat <= 1'b1;
                    end
`endif
                end
                WAIT_REL: begin
                    if (w_fall) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.short_press  = r_short;
    assign bus.long_press   = r_long;
    assign bus.double_click = r_dclick;
    assign bus.held         = r_held;
`ifdef AUTO_REPEAT_EN
    assign bus.repeat_pulse = r_repeat;
`else
    assign bus.repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=10, LONG_T=8, DCLICK_T=4, REPEAT_T=2.
module tb_button_event_decoder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   r_cyc;

    button_event_decoder_if bus();

    button_event_decoder #(
        .TICK_DIV (10),
        .LONG_T   (8),
        .DCLICK_T (4),
        .REPEAT_T (2),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; tick edges are the multiples of 10.
    always @(posedge clk or posedge reset) begin
        if (reset) r_cyc <= 0;
        else       r_cyc <= r_cyc + 1;
    end

    function automatic logic [4:0] outs();
        return {bus.short_press, bus.long_press, bus.double_click, bus.repeat_pulse, bus.held};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.db_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_during outs=%b expected=%b", outs(), 5'b0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (outs() !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_after outs=%b expected=%b", outs(), 5'b0);
        end
    endtask

    task automatic test_short();
        int f, exp_e, got_e, n_short, n_other, held_bad;
        n_short = 0; n_other = 0; held_bad = 0; got_e = -1;
        bus.db_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b1) held_bad++;
            if (outs() !== 5'b00001) n_other++;
        end
        bus.db_in = 1'b0;
        f = r_cyc + 1;
        exp_e = (f / 10 + 4) * 10;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b0) held_bad++;
            if (bus.short_press === 1'b1) begin n_short++; got_e = r_cyc; end
            if (bus.long_press | bus.double_click | bus.repeat_pulse) n_other++;
        end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL short_held bad_cycles=%0d expected=0", held_bad); end
        n_checks++;
        if (n_short != 1) begin n_fail++; $display("FAIL short_count got=%0d expected=1", n_short); end
        n_checks++;
        if (got_e != exp_e) begin n_fail++; $display("FAIL short_time edge=%0d expected=%0d", got_e, exp_e); end
        n_checks++;
        if (n_other != 0) begin n_fail++; $display("FAIL short_other_pulses got=%0d expected=0", n_other); end
    endtask

    task automatic test_long();
        int p, exp_e, got_e, n_long, n_other, held_bad;
        n_long = 0; n_other = 0; held_bad = 0; got_e = -1;
        bus.db_in = 1'b1;
        p = r_cyc + 1;
        exp_e = (p / 10 + 8) * 10;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b1) held_bad++;
            if (bus.long_press === 1'b1) begin n_long++; got_e = r_cyc; end
            if (bus.short_press | bus.double_click) n_other++;
        end
        bus.db_in = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b0) held_bad++;
            if (outs() !== 5'b0) n_other++;
        end
        n_checks++;
        if (n_long != 1) begin n_fail++; $display("FAIL long_count got=%0d expected=1", n_long); end
        n_checks++;
        if (got_e != exp_e) begin n_fail++; $display("FAIL long_time edge=%0d expected=%0d", got_e, exp_e); end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL long_held bad_cycles=%0d expected=0", held_bad); end
        n_checks++;
        if (n_other != 0) begin n_fail++; $display("FAIL long_other_pulses got=%0d expected=0", n_other); end
    endtask

    task automatic test_double();
        int dc_idx, n_dc, n_short, held_bad;
        dc_idx = -1; n_dc = 0; n_short = 0; held_bad = 0;
        bus.db_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.short_press === 1'b1) n_short++;
            if (bus.double_click === 1'b1) n_dc++;
        end
        bus.db_in = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.short_press === 1'b1) n_short++;
            if (bus.double_click === 1'b1) n_dc++;
        end
        bus.db_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b1) held_bad++;
            if (bus.short_press === 1'b1) n_short++;
            if (bus.double_click === 1'b1) begin n_dc++; dc_idx = i; end
        end
        bus.db_in = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b0) held_bad++;
            if (bus.short_press === 1'b1) n_short++;
            if (bus.double_click === 1'b1) n_dc++;
        end
        n_checks++;
        if (n_dc != 1 || dc_idx != 1) begin
            n_fail++;
            $display("FAIL dclick_pulse count=%0d at_cycle=%0d expected count=1 at_cycle=1", n_dc, dc_idx);
        end
        n_checks++;
        if (n_short != 0) begin n_fail++; $display("FAIL dclick_no_short got=%0d expected=0", n_short); end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL dclick_held bad_cycles=%0d expected=0", held_bad); end
    endtask

    task automatic test_repeat();
        int p, exp_l, got_l, n_long, n_rep, exp_rep, rep_bad;
        n_long = 0; n_rep = 0; rep_bad = 0; got_l = -1;
        bus.db_in = 1'b1;
        p = r_cyc + 1;
        exp_l = (p / 10 + 8) * 10;
        exp_rep = 0;
`ifdef AUTO_REPEAT_EN
        for (int m = 1; exp_l + 20 * m <= p + 149; m++) exp_rep++;
`endif
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (bus.long_press === 1'b1) begin n_long++; got_l = r_cyc; end
            if (bus.repeat_pulse === 1'b1) begin
                n_rep++;
                if (r_cyc != exp_l + 20 * n_rep) rep_bad++;
            end
        end
        bus.db_in = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.repeat_pulse === 1'b1) begin n_rep++; rep_bad++; end
        end
        n_checks++;
        if (n_long != 1 || got_l != exp_l) begin
            n_fail++;
            $display("FAIL repeat_long count=%0d edge=%0d expected count=1 edge=%0d", n_long, got_l, exp_l);
        end
        n_checks++;
        if (n_rep != exp_rep) begin n_fail++; $display("FAIL repeat_count got=%0d expected=%0d", n_rep, exp_rep); end
        n_checks++;
        if (rep_bad != 0) begin n_fail++; $display("FAIL repeat_timing bad=%0d expected=0", rep_bad); end
    endtask

    task automatic test_reset_mid();
        int n_pulse, held_bad;
        n_pulse = 0; held_bad = 0;
        bus.db_in = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.held !== 1'b0) begin n_fail++; $display("FAIL rstmid_async held=%b expected=0", bus.held); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b0) held_bad++;
            if (outs() !== 5'b0) n_pulse++;
        end
        bus.db_in = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.held !== 1'b0) held_bad++;
            if (outs() !== 5'b0) n_pulse++;
        end
        n_checks++;
        if (held_bad != 0) begin n_fail++; $display("FAIL rstmid_held bad_cycles=%0d expected=0", held_bad); end
        n_checks++;
        if (n_pulse != 0) begin n_fail++; $display("FAIL rstmid_pulses got=%0d expected=0", n_pulse); end
        bus.db_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.held !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_press held=%b expected=1", bus.held); end
        repeat (10) @(negedge clk);
        bus.db_in = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        int f, t4, n_short, guard;
        n_short = 0; guard = 0;
        bus.db_in = 1'b1;
        repeat (20) @(negedge clk);
        bus.db_in = 1'b0;
        f = r_cyc + 1;
        t4 = (f / 10 + 4) * 10;
        while (r_cyc < t4 - 1 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (bus.short_press === 1'b1) n_short++;
        end
        n_checks++;
        if (r_cyc != t4 - 1) begin n_fail++; $display("FAIL same_align cyc=%0d expected=%0d", r_cyc, t4 - 1); end
        bus.db_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.double_click !== 1'b1 || bus.short_press !== 1'b0) begin
            n_fail++;
            $display("FAIL same_edge_tick dclick=%b short=%b expected dclick=1 short=0",
                     bus.double_click, bus.short_press);
        end
        repeat (5) @(negedge clk);
        bus.db_in = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.short_press === 1'b1) n_short++;
        end
        n_checks++;
        if (n_short != 0) begin n_fail++; $display("FAIL same_no_short got=%0d expected=0", n_short); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.db_in = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_repeat();
        test_reset_mid();
        test_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
